// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared operation encoding, FSM states and divider constants for the HI/LO unit
package hilo_muldiv_pkg;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} muldiv_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} muldiv_state_t;
  localparam int DIV_ITERS = 32;
endpackage

// File: rtl/hilo_muldiv_divider_radix2.sv
// divider_radix2: restoring divider on unsigned magnitudes, one quotient bit per cycle MSB first
module divider_radix2
  import hilo_muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_valid,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);
  logic [31:0] r_rem, r_quot, r_dsr;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        w_ge;
  logic [31:0] w_sub;
  // r_quot shifts the dividend out of its MSB while quotient bits enter at the LSB
  assign w_ge    = {r_rem, r_quot[31]} >= {1'b0, r_dsr};
  assign w_sub   = {r_rem[30:0], r_quot[31]} - r_dsr;
  assign o_valid = r_busy && r_cnt == 6'(DIV_ITERS);
  assign o_quot  = r_quot;
  assign o_rem   = r_rem;
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dsr  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dsr  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (r_busy && r_cnt != 6'(DIV_ITERS)) begin
      r_rem  <= w_ge ? w_sub : {r_rem[30:0], r_quot[31]};
      r_quot <= {r_quot[30:0], w_ge};
      r_cnt  <= r_cnt + 6'd1;
    end
  end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: architectural HI/LO registers with multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO writes
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_start,
  input  muldiv_op_t  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_hi_wdata,
  input  logic [31:0] i_lo_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(DIV_ITERS - 1);
  muldiv_state_t r_state, w_next;
  muldiv_op_t    r_op;
  logic [31:0]   r_a, r_b, r_hi, r_lo;
  logic [7:0]    r_cnt;
  logic          r_done, w_commit, w_accept, w_div_valid, w_div_sgn, w_mul_sx;
  logic [31:0]   w_mag_a, w_mag_b, w_quot, w_rem, w_res_hi, w_res_lo;
  logic [63:0]   w_prod;
  assign w_div_sgn = i_op == OP_DIV;
  assign w_mag_a   = (w_div_sgn && i_a[31]) ? -i_a : i_a;
  assign w_mag_b   = (w_div_sgn && i_b[31]) ? -i_b : i_b;
  assign w_accept  = r_state == S_IDLE && w_next != S_IDLE;
  divider_radix2 u_div (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_start    (w_accept && w_next == S_DIV),
    .i_abort    (i_flush || r_state == S_FIX),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_valid    (w_div_valid),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );
  always_comb begin
    w_next   = S_IDLE;
    w_commit = 1'b0;
    if (!i_flush)
      case (r_state)
        S_IDLE: w_next = !i_start ? S_IDLE : (i_op >= OP_DIV) ? S_DIV : S_MUL;
        S_MUL: begin
          w_next   = (r_cnt == MUL_LAST) ? S_IDLE : S_MUL;
          w_commit = r_cnt == MUL_LAST;
        end
        S_DIV: w_next = (r_cnt == DIV_LAST) ? S_FIX : S_DIV;
        default: w_commit = w_div_valid;
      endcase
  end
  // sign fix and the architectural corner cases (divide by zero) are resolved at commit
  assign w_mul_sx = r_op == OP_MULT;
  assign w_prod   = {{32{w_mul_sx & r_a[31]}}, r_a} * {{32{w_mul_sx & r_b[31]}}, r_b};
  assign w_res_lo = (r_state == S_MUL) ? w_prod[31:0] : (r_b == '0) ? '1 :
                    (r_op == OP_DIV && (r_a[31] ^ r_b[31])) ? -w_quot : w_quot;
  assign w_res_hi = (r_state == S_MUL) ? w_prod[63:32] : (r_b == '0) ? r_a :
                    (r_op == OP_DIV && r_a[31]) ? -w_rem : w_rem;
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state && r_state != S_IDLE) ? r_cnt + 8'd1 : 8'd0;
      r_done  <= w_commit;
      if (w_accept) begin
        r_op <= i_op;
        r_a  <= i_a;
        r_b  <= i_b;
      end
      if (i_hi_we) r_hi <= i_hi_wdata;
      else if (w_commit) r_hi <= w_res_hi;
      if (i_lo_we) r_lo <= i_lo_wdata;
      else if (w_commit) r_lo <= w_res_lo;
    end
  end
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed and random checks of hilo_muldiv against an arithmetic HI/LO model
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  muldiv_op_t op = OP_MULT;
  logic [31:0] a = '0, b = '0, hi_wdata = '0, lo_wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv #(.MUL_CYCLES(3)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_flush(flush), .i_hi_we(hi_we), .i_lo_we(lo_we), .i_hi_wdata(hi_wdata),
    .i_lo_wdata(lo_wdata), .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from the architectural definition using plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = muldiv_op_t'(o);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = muldiv_op_t'($urandom_range(3));
    a = $urandom;
    b = $urandom;
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  // waits the architectural latency; poke fires an extra start while busy that must be ignored
  task automatic finish_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input bit poke);
    logic [63:0] r;
    int lat;
    r = model(o, x, y);
    lat = o[1] ? 33 : 3;
    for (int k = 1; k <= lat; k++) begin
      if (poke && k == 1) begin
        @(negedge clk);
        start = 1'b1;
        op = o[1] ? OP_MULT : OP_DIV;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == lat - 1) begin
        chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
        chk({tag, "_done_pre"}, 32'(done), 32'd0);
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, r[63:32]);
    chk({tag, "_lo"}, lo, r[31:0]);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y);
    finish_op(tag, o, x, y, 1'b0);
  endtask

  initial begin
    int nd;
    logic [63:0] r;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run("mult", 2'd0, -32'sd3, 32'd5);
    run("multu", 2'd1, -32'sd3, 32'd5);
    run("div", 2'd2, -32'sd7, 32'd2);
    run("divu", 2'd3, 32'd7, 32'd2);
    run("div_by0", 2'd2, 32'd1234, 32'd0);
    run("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    finish_op("ignored", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    @(posedge clk);
    #1;
    chk("ignored_idle", 32'(busy), 32'd0);
    issue(2'd3, $urandom, $urandom);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      nd += int'(done);
      @(posedge clk);
      #1;
    end
    chk("flush_no_done", 32'(nd), 32'd0);
    chk("flush_hi", hi, exp_hi);
    chk("flush_lo", lo, exp_lo);
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op = OP_DIV;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("start_flush_idle", 32'(busy), 32'd0);
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    hi_wdata = 32'h1357_9BDF;
    lo_wdata = 32'h2468_ACE0;
    #1;
    chk("no_bypass_hi", hi, exp_hi);
    chk("no_bypass_lo", lo, exp_lo);
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mthi", hi, 32'h1357_9BDF);
    chk("mtlo", lo, 32'h2468_ACE0);
    issue(2'd0, 32'd100000, -32'sd7);
    r = model(2'd0, 32'd100000, -32'sd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    hi_we = 1'b1;
    hi_wdata = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("wb_win_done", 32'(done), 32'd1);
    chk("wb_win_hi", hi, 32'hAAAA_AAAA);
    chk("wb_win_lo", lo, r[31:0]);
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(3));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'd0 : (i % 4 == 2) ? 32'($urandom_range(1, 40)) : $urandom;
      run("rand", ro, ra, rb);
    end
    issue(2'd2, 32'd99, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run("post_rst", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
